// File: rtl/anfield_timer_slave.sv
// rtl/anfield_timer_slave.sv - 64-bit memory-mapped machine timer on data-bus slave 2; optional periodic mode via TIMER_AUTO_RELOAD_EN
module anfield_timer_slave #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [63:0] ReadAddrIn,
    output logic [63:0] ReadDataOut,
    output logic        ReadReady,
    input  logic [63:0] WriteAddrIn,
    input  logic [63:0] WriteDataIn,
    input  logic        WriteEnableIn,
    input  logic [3:0]  WriteStrbIn,
    output logic        WriteReady,
    output logic        TimerIrq
);

    localparam int               PSC_W    = $clog2(PRESCALE) + 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        REG_MTIME = 2'd0,
        REG_CMP   = 2'd1,
        REG_CTRL  = 2'd2,
        REG_NONE  = 2'd3
    } reg_sel_t;

    typedef enum logic { R_IDLE, R_RESP } rd_state_t;
    typedef enum logic { W_IDLE, W_ACK  } wr_state_t;

    // Only offset[4:3] picks the register; anything outside the 0x18 window maps to REG_NONE.
    function automatic reg_sel_t decode(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE_ADDR;
        if ((addr < BASE_ADDR) || (off >= 64'h18)) return REG_NONE;
        return reg_sel_t'(off[4:3]);
    endfunction

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             ctrl_en;
    logic             ctrl_ie;
    logic [PSC_W-1:0] psc;
    logic             tick;
    logic [63:0]      mtime_inc;
    logic             irq_nxt;

    rd_state_t        rd_state, rd_state_nxt;
    logic             rd_capture;
    logic             rd_ready_nxt;
    logic [63:0]      rd_mux;

    wr_state_t        wr_state, wr_state_nxt;
    logic             wr_commit;
    reg_sel_t         wr_sel;
    logic             wr_mtime, wr_cmp, wr_ctrl;
    logic [63:0]      wr_mask;

    assign wr_mask   = {{16{WriteStrbIn[3]}}, {16{WriteStrbIn[2]}},
                        {16{WriteStrbIn[1]}}, {16{WriteStrbIn[0]}}};
    assign wr_sel    = decode(WriteAddrIn);
    assign wr_mtime  = wr_commit && (wr_sel == REG_MTIME);
    assign wr_cmp    = wr_commit && (wr_sel == REG_CMP);
    assign wr_ctrl   = wr_commit && (wr_sel == REG_CTRL);
    assign tick      = ctrl_en && (psc == PSC_LAST);
    assign mtime_inc = mtime + 64'd1;

`ifdef TIMER_AUTO_RELOAD_EN
    logic reload;
    assign reload  = tick && (mtime_inc >= mtimecmp);
    assign irq_nxt = ctrl_ie && reload;
`else
    assign irq_nxt = ctrl_ie && (mtime >= mtimecmp);
`endif

    // Read FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rd_state <= R_IDLE;
        else          rd_state <= rd_state_nxt;
    end

    // Read FSM next state: a nonzero address starts a request, response lasts one cycle
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE: if (ReadAddrIn != 64'd0) rd_state_nxt = R_RESP;
            R_RESP: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs: capture strobe in idle, ready pulse leaving the response state
    always_comb begin
        rd_capture   = (rd_state == R_IDLE) && (ReadAddrIn != 64'd0);
        rd_ready_nxt = (rd_state == R_RESP);
    end

    // Read data mux over current (pre-write) register values
    always_comb begin
        case (decode(ReadAddrIn))
            REG_MTIME: rd_mux = mtime;
            REG_CMP:   rd_mux = mtimecmp;
            REG_CTRL:  rd_mux = {62'd0, ctrl_ie, ctrl_en};
            default:   rd_mux = 64'd0;
        endcase
    end

    // Read data holds until the next captured request; ready is a registered pulse
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ReadDataOut <= 64'd0;
            ReadReady   <= 1'b0;
        end else begin
            ReadReady <= rd_ready_nxt;
            if (rd_capture) ReadDataOut <= rd_mux;
        end
    end

    // Write FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) wr_state <= W_IDLE;
        else          wr_state <= wr_state_nxt;
    end

    // Write FSM next state: enable is ignored while acknowledging
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE: if (WriteEnableIn) wr_state_nxt = W_ACK;
            W_ACK:  wr_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: commit on the accepting edge, ready while acknowledging
    always_comb begin
        wr_commit  = (wr_state == W_IDLE) && WriteEnableIn;
        WriteReady = (wr_state == W_ACK);
    end

    // Prescaler restarts on disable, on wrap, and on any software write to MTIME
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)                        psc <= '0;
        else if (wr_mtime || !ctrl_en || tick) psc <= '0;
        else                                 psc <= psc + PSC_W'(1);
    end

    // MTIME: software write beats a same-cycle tick; increment wraps silently
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)      mtime <= 64'd0;
        else if (wr_mtime) mtime <= (mtime & ~wr_mask) | (WriteDataIn & wr_mask);
`ifdef TIMER_AUTO_RELOAD_EN
        else if (reload)   mtime <= 64'd0;
`endif
        else if (tick)     mtime <= mtime_inc;
    end

    // MTIMECMP and CTRL lane-masked writes
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mtimecmp <= '1;
            ctrl_en  <= 1'b0;
            ctrl_ie  <= 1'b0;
        end else begin
            if (wr_cmp) mtimecmp <= (mtimecmp & ~wr_mask) | (WriteDataIn & wr_mask);
            if (wr_ctrl && WriteStrbIn[0]) begin
                ctrl_en <= WriteDataIn[0];
                ctrl_ie <= WriteDataIn[1];
            end
        end
    end

    // Registered interrupt from current register values
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) TimerIrq <= 1'b0;
        else          TimerIrq <= irq_nxt;
    end

endmodule
